// File: rtl/snap_capture_ctrl.sv
// Snapshot capture sequencer: arm/trigger/stop from a software control word, writes samples into BRAM.
// Define SNAP_CIRC_EN to build the circular (wrap until stop) capture variant.
module snap_capture_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       ctrl_word,
    input  logic              ext_trig,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic [31:0]       status_word
);

    // state   | meaning
    // IDLE    | waiting for arm rising edge
    // ARMED   | waiting for ext_trig (or stop)
    // CAPTURE | writing qualified samples
    // DONE    | capture finished, holding count until re-arm
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   ONE_C = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              wrapped_q, wrapped_d;
    logic              arm_q, stop_q;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [31:0]       status_q, status_d;

    logic            arm_p, stop_p, wr_ok, do_wr;
    logic [ADDR_W:0] count_inc;

    always_comb begin
        arm_p     = ctrl_word[0] & ~arm_q;
        stop_p    = ctrl_word[3] & ~stop_q;
        wr_ok     = din_valid | ~ctrl_word[2];
        state_d   = state_q;
        count_d   = count_q;
        wrapped_d = wrapped_q;
        do_wr     = 1'b0;
`ifdef SNAP_CIRC_EN
        // low bits roll over; the MSB latches so software sees a full buffer once wrapped
        count_inc = {count_q[ADDR_W] | (&count_q[ADDR_W-1:0]), count_q[ADDR_W-1:0] + ONE_A};
`else
        count_inc = count_q + ONE_C;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm_p) begin
                    count_d   = '0;
                    wrapped_d = 1'b0;
                    state_d   = ctrl_word[1] ? S_CAPTURE : S_ARMED;
                end
            end
            S_ARMED: begin
                if (stop_p) begin
                    state_d = S_IDLE;
                end else if (ext_trig) begin
                    state_d = S_CAPTURE;
                    do_wr   = wr_ok;
                end
            end
            default: begin
                do_wr = wr_ok;
`ifdef SNAP_CIRC_EN
                if (stop_p) state_d = S_DONE;
`else
                if (stop_p || (do_wr && count_inc[ADDR_W])) state_d = S_DONE;
`endif
            end
        endcase

        if (do_wr) begin
            count_d = count_inc;
`ifdef SNAP_CIRC_EN
            if (&count_q[ADDR_W-1:0]) wrapped_d = 1'b1;
`endif
        end
`ifndef SNAP_CIRC_EN
        wrapped_d = 1'b0;
`endif

        we_d   = do_wr;
        addr_d = do_wr ? count_q[ADDR_W-1:0] : addr_q;
        din_d  = do_wr ? din : din_q;

        status_d = {(state_q == S_DONE),
                    (state_q == S_ARMED) || (state_q == S_CAPTURE),
                    wrapped_q,
                    {(28-ADDR_W){1'b0}},
                    count_q};
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            wrapped_q <= 1'b0;
            arm_q     <= 1'b0;
            stop_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            status_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
            arm_q     <= ctrl_word[0];
            stop_q    <= ctrl_word[3];
            we_q      <= we_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            status_q  <= status_d;
        end
    end

    assign bram_we     = we_q;
    assign bram_addr   = addr_q;
    assign bram_din    = din_q;
    assign status_word = status_q;

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Scoreboard bench for snap_capture_ctrl; exercises the circular variant when SNAP_CIRC_EN is defined.
module tb_snap_capture_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic              clk;
    logic              rst_n;
    logic [31:0]       ctrl_word;
    logic              ext_trig;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic [31:0]       status_word;

    int  n_cmp;
    int  n_err;
    wr_t exp_q[$];
    wr_t exp_e;

    snap_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .user_clk    (clk),
        .user_rst_n  (rst_n),
        .ctrl_word   (ctrl_word),
        .ext_trig    (ext_trig),
        .din         (din),
        .din_valid   (din_valid),
        .bram_we     (bram_we),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din),
        .status_word (status_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mk(input logic [31:0] tag, input int i);
        return {tag, 32'(i)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a, input logic [DATA_W-1:0] d);
        wr_t w;
        w.a = ADDR_W'(a);
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every BRAM write must match the oldest expected write.
    always @(negedge clk) begin
        if (bram_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data 0x%016h expected no write", bram_addr, bram_din);
            end else begin
                exp_e = exp_q.pop_front();
                if (bram_addr !== exp_e.a || bram_din !== exp_e.d) begin
                    n_err++;
                    $display("FAIL write: got addr %0d data 0x%016h expected addr %0d data 0x%016h",
                             bram_addr, bram_din, exp_e.a, exp_e.d);
                end
            end
        end
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        ctrl_word = 32'h1;
        ext_trig  = 1'b0;
        din       = '0;
        din_valid = 1'b0;

        // reset with arm held high
        repeat (4) begin
            step();
            check("rst_status", status_word, 32'h0);
            check("rst_we", {31'b0, bram_we}, 32'h0);
        end
        rst_n     = 1'b1;
        ctrl_word = 32'h0;
        step();
        step();
        ctrl_word = 32'h1;
        step();
        step();
        check("armed_status", status_word, 32'h4000_0000);
        ctrl_word = 32'h9;
        step();
        step();
        check("armed_stop_idle", status_word, 32'h0);
        ctrl_word = 32'h0;
        step();

`ifndef SNAP_CIRC_EN
        // full linear capture with trig_imm
        ctrl_word = 32'h3;
        din_valid = 1'b1;
        step();
        for (int i = 0; i < 1024; i++) begin
            din = mk(32'hB000_0000, i);
            push(i, din);
            step();
        end
        step();
        check("full_status", status_word, 32'h8000_0400);
        ctrl_word = 32'h0;
        step();
`endif

        // valid_only, ext_trig pulse, sparse din_valid, stop with a qualified write
        ctrl_word = 32'h5;
        ext_trig  = 1'b0;
        din_valid = 1'b0;
        step();
        step();
        step();
        ext_trig  = 1'b1;
        din_valid = 1'b1;
        din       = mk(32'hC000_0000, 0);
        push(0, din);
        step();
        ext_trig = 1'b0;
        begin
            int cnt;
            cnt = 1;
            for (int k = 1; k <= 30; k++) begin
                din_valid = (k % 3 == 0);
                din       = mk(32'hC000_0000, k);
                if (din_valid) begin
                    push(cnt, din);
                    cnt++;
                end
                step();
            end
            ctrl_word = 32'hD;
            din_valid = 1'b1;
            din       = mk(32'hC000_0000, 99);
            push(cnt, din);
            step();
        end
        din_valid = 1'b0;
        step();
        check("valid_only_status", status_word, 32'h8000_000C);
        ctrl_word = 32'h0;
        step();

        // stop after 100 writes, then re-arm
        ctrl_word = 32'h1;
        din_valid = 1'b1;
        step();
        ext_trig = 1'b1;
        for (int i = 0; i < 100; i++) begin
            din = mk(32'hD000_0000, i);
            push(i, din);
            step();
            ext_trig = 1'b0;
        end
        ctrl_word = 32'hD;
        din_valid = 1'b0;
        step();
        din_valid = 1'b1;
        step();
        check("stop100_status", status_word, 32'h8000_0064);
        repeat (4) step();
        check("stop100_hold", status_word, 32'h8000_0064);
        ctrl_word = 32'h0;
        step();
        ctrl_word = 32'h1;
        step();
        step();
        check("rearm_status", status_word, 32'h4000_0000);

        // arm and stop rising together during CAPTURE
        ext_trig = 1'b1;
        din      = mk(32'hE000_0000, 0);
        push(0, din);
        step();
        ext_trig = 1'b0;
        din      = mk(32'hE000_0000, 1);
        push(1, din);
        step();
        ctrl_word = 32'h0;
        din       = mk(32'hE000_0000, 2);
        push(2, din);
        step();
        ctrl_word = 32'h9;
        din       = mk(32'hE000_0000, 3);
        push(3, din);
        step();
        step();
        check("arm_stop_done", status_word, 32'h8000_0004);
        ctrl_word = 32'h0;
        step();
        check("done_hold", status_word, 32'h8000_0004);

`ifdef SNAP_CIRC_EN
        // circular capture: 1500 writes then stop
        ctrl_word = 32'h3;
        din_valid = 1'b1;
        step();
        for (int i = 0; i < 1500; i++) begin
            din = mk(32'hF000_0000, i);
            push(i % 1024, din);
            step();
        end
        ctrl_word = 32'hF;
        din_valid = 1'b0;
        step();
        step();
        check("circ_status", status_word, 32'hA000_05DC);
        ctrl_word = 32'h0;
        step();
`endif

        repeat (3) step();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_writes: got %0d outstanding expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/snap_capture_ctrl.md
Name: snap_capture_ctrl

Overview:
- Sequencer for one snapshot capture channel (e.g. vacc5).
- Takes arm/trigger/stop commands from a 32-bit software control word, qualifies incoming samples, and drives write-enable, address and data into the snapshot BRAM.
- Produces a 32-bit status/address word that feeds the matching simulink2ppc software register (user_data_in), so software can poll completion and fill level.
- Runs entirely in the user_clk domain.

Parameters:
- ADDR_W, 10, BRAM address width; depth = 2^ADDR_W words.
- DATA_W, 64, sample/BRAM data width.

Ports:
- user_clk  in  1  fabric clock; all logic on rising edge.
- user_rst_n  in  1  synchronous, active-low reset.
- ctrl_word  in  32  software control register:
  - bit0 arm (rising-edge sensitive)
  - bit1 trig_imm (trigger immediately on arm)
  - bit2 valid_only (write only when din_valid)
  - bit3 stop (rising-edge sensitive)
- ext_trig  in  1  hardware trigger, level sampled while ARMED.
- din  in  DATA_W  sample data.
- din_valid  in  1  sample qualifier.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_W  BRAM write address.
- bram_din  out  DATA_W  BRAM write data.
- status_word  out  32  fields:
  - [31] done
  - [30] busy
  - [29] wrapped
  - [28:ADDR_W+1] zero
  - [ADDR_W:0] words written (0..2^ADDR_W)

Behaviour:
- Reset (user_rst_n=0 at a clock edge):
  - state=IDLE; bram_we=0; bram_addr=0; bram_din=0; status_word=0.
  - Edge-detect history for arm and stop cleared to 0, so an arm held high through reset does not fire.
  - Reset mid-capture aborts; no further writes.
- Edge detection:
  - arm_p = ctrl_word[0] & ~arm_q; stop_p = ctrl_word[3] & ~stop_q.
  - arm_q and stop_q are registered each cycle.
- Write qualifier: wr_ok = din_valid | ~ctrl_word[2].
- States:
  - IDLE:
    - arm_p → clear count, wrapped and done, then go to ARMED.
    - If trig_imm=1, go directly to CAPTURE instead.
  - ARMED:
    - busy=1.
    - ext_trig=1 → CAPTURE; the trigger-cycle sample, if wr_ok, is the first word written.
    - stop_p → IDLE with done=0.
  - CAPTURE:
    - busy=1.
    - Each cycle with wr_ok: write din at address = count; count++.
    - When count reaches 2^ADDR_W → DONE.
    - stop_p → DONE immediately; a write qualified in the same cycle is still performed.
  - DONE:
    - done=1, busy=0.
    - Hold until arm_p, which restarts exactly as from IDLE.
- Write pipeline, 1-cycle latency:
  - Sample registered at edge N appears on bram_din/bram_addr with bram_we=1 at edge N+1.
  - bram_we deasserts the cycle after the last qualified write.
- Count arithmetic:
  - count is ADDR_W+1 bits; bram_addr = count[ADDR_W-1:0].
  - Full capture reports count = 2^ADDR_W, e.g. 1024 for ADDR_W=10.
- status_word is registered and updates one cycle after the state/count change.
- Simultaneous events:
  - arm_p and stop_p in the same cycle: stop has priority in ARMED/CAPTURE; arm has priority in IDLE/DONE.
  - arm_p during ARMED/CAPTURE is ignored.

Optional Feature:
- SNAP_CIRC_EN defined:
  - CAPTURE wraps instead of ending: count[ADDR_W-1:0] rolls 1023→0 and wrapped is set sticky.
  - count saturates its MSB, i.e. reports 2^ADDR_W once wrapped.
  - status_word[ADDR_W-1:0] reports the next write address.
  - CAPTURE exits only on stop_p.
- SNAP_CIRC_EN undefined:
  - wrapped is tied to 0.
  - Capture ends at full, as described above.

Test Plan:
- Reset with ctrl_word=0x1 held → no capture; status_word=0; bram_we=0 throughout; release reset and toggle bit0 low→high → ARMED, status_word[30]=1.
- ctrl_word=0x3 (arm+trig_imm), din_valid=1 continuous, ADDR_W=10 → 1024 writes at addresses 0..1023, first bram_we one cycle after CAPTURE entry; status_word=0x8000_0400.
- Arm with valid_only=1, din_valid asserted every 3rd cycle, ext_trig pulse → only qualified samples written, addresses contiguous; count increments by 1 per valid.
- Mid-capture stop rising edge after 100 writes → done=1, count=100 (0x8000_0064); no further bram_we; re-arm clears to 0.
- ARMED then stop_p without trigger → IDLE, status_word=0, no writes; stop and arm in the same cycle while in CAPTURE → DONE.
- With SNAP_CIRC_EN, 1500 valid writes then stop → bram_addr wrapped to 0 after 1023; status_word[29]=1, [31]=1, [9:0]=476.
